// File: rtl/ahb_lite_xbar_if.sv
// Bus bundle between the AHB-Lite master, the xbar and its slave slots.
// The slave modport is the xbar's view; the master modport is the surrounding system's view.
interface ahb_lite_xbar_if #(
  parameter int NSLAVES = 4,
  parameter int DW      = 32
);
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [DW-1:0]         HWDATA;
  logic [DW-1:0]         HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [NSLAVES-1:0]    HSEL;
  logic [31:0]           HADDRDEL;
  logic                  HWRITEDEL;
  logic [NSLAVES*DW-1:0] HRDATA_S;
  logic [NSLAVES-1:0]    HREADYOUT_S;
  logic [NSLAVES-1:0]    HRESP_S;
  logic                  timeout_flag;

  modport master (
    output HADDR, HTRANS, HWRITE, HWDATA, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY, HRESP, HSEL, HADDRDEL, HWRITEDEL, timeout_flag
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HWDATA, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP, HSEL, HADDRDEL, HWRITEDEL, timeout_flag
  );
endinterface

// File: rtl/ahb_lite_xbar.sv
// Single-master AHB-Lite interconnect: address decode, data-phase mux and a two-cycle ERROR default slave.
// Optional wait-state watchdog enabled by defining AHB_XBAR_TIMEOUT_EN.
module ahb_lite_xbar #(
  parameter int                    NSLAVES  = 4,
  parameter int                    DW       = 32,
  parameter logic [NSLAVES*32-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                               32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLAVES*32-1:0] SLV_MASK = {4{32'hF000_0000}},
  parameter int                    TIMEOUT  = 64
) (
  input logic           HCLK,
  input logic           HRESET,
  ahb_lite_xbar_if.slave bus
);

  localparam int             OW          = $clog2(NSLAVES + 2);
  localparam logic [OW-1:0]  OWN_DEFAULT = OW'(NSLAVES);
  localparam logic [OW-1:0]  OWN_NONE    = OW'(NSLAVES + 1);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} dflt_state_t;

  dflt_state_t        state;
  dflt_state_t        state_next;
  logic [OW-1:0]      owner;
  logic [OW-1:0]      addr_owner;
  logic [OW-1:0]      hit_idx;
  logic [NSLAVES-1:0] first_hit;
  logic               hit_found;
  logic [31:0]        haddr_del;
  logic               hwrite_del;
  logic               hready;
  logic               hresp;
  logic [DW-1:0]      hrdata;
  logic               timeout_hit;
  logic               unused_inputs;

  // Default-slave writes are dropped, so write data never reaches this block.
  assign unused_inputs = ^{bus.HTRANS[0], bus.HWDATA};

  // Priority decode: the lowest-index matching region wins on overlap.
  always_comb begin
    first_hit  = '0;
    hit_found  = 1'b0;
    hit_idx    = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!hit_found &&
          ((bus.HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        hit_found    = 1'b1;
        hit_idx      = OW'(i);
        first_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    addr_owner = OWN_NONE;
    if (bus.HTRANS[1]) begin
      addr_owner = hit_found ? hit_idx : OWN_DEFAULT;
    end
  end

  assign bus.HSEL = bus.HTRANS[1] ? first_hit : '0;

  // Address-phase capture; a timeout abort hands the data phase to the default slave.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      haddr_del  <= '0;
      hwrite_del <= 1'b0;
      owner      <= OWN_NONE;
    end else if (timeout_hit) begin
      owner <= OWN_DEFAULT;
    end else if (hready) begin
      haddr_del  <= bus.HADDR;
      hwrite_del <= bus.HWRITE;
      owner      <= addr_owner;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (timeout_hit || (hready && (addr_owner == OWN_DEFAULT))) begin
          state_next = ERR1;
        end
      end
      ERR1:    state_next = ERR2;
      ERR2:    state_next = (addr_owner == OWN_DEFAULT) ? ERR1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Error states override the mux; otherwise the data-phase owner drives the response.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    case (state)
      ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
      end
      ERR2: begin
        hresp = 1'b1;
      end
      default: begin
        for (int i = 0; i < NSLAVES; i++) begin
          if (owner == OW'(i)) begin
            hrdata = bus.HRDATA_S[DW*i +: DW];
            hready = bus.HREADYOUT_S[i];
            hresp  = bus.HRESP_S[i];
          end
        end
      end
    endcase
  end

`ifdef AHB_XBAR_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] stall_cnt;
  logic          slot_stall;
  logic          flag;

  assign slot_stall  = (owner < OWN_DEFAULT) && (state == IDLE) && !hready;
  // Abort on the edge where the count would reach TIMEOUT-1.
  assign timeout_hit = slot_stall && (stall_cnt == CW'(TIMEOUT - 2));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      stall_cnt <= '0;
      flag      <= 1'b0;
    end else begin
      if (slot_stall && !timeout_hit) begin
        stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
      if (timeout_hit) begin
        flag <= 1'b1;
      end
    end
  end

  assign bus.timeout_flag = flag;
`else
  logic unused_timeout;

  assign unused_timeout   = TIMEOUT[0];
  assign timeout_hit      = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.HRDATA    = hrdata;
  assign bus.HREADY    = hready;
  assign bus.HRESP     = hresp;
  assign bus.HADDRDEL  = haddr_del;
  assign bus.HWRITEDEL = hwrite_del;

endmodule
